// File: rtl/hard_out_sequencer_if.sv
// Control/status bundle between a sequence controller and hard_out_sequencer.
interface hard_out_sequencer_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 3,
  parameter int STEPS    = 4
);
  localparam int STEP_W = $clog2(STEPS + 1);

  logic                      start;
  logic                      reload;
  logic                      hold;
  logic [WIDTH-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] out_bus;
  logic [STEP_W-1:0]         step;
  logic                      busy;
  logic                      done;

  modport master (output start, reload, hold, sel,
                  input  out_bus, step, busy, done);
  modport slave  (input  start, reload, hold, sel,
                  output out_bus, step, busy, done);
endinterface

// File: rtl/hard_out_sequencer.sv
// Multi-channel output sequencer: loads per-channel seeds, then on each
// accepted start applies STEPS additive updates (fixed odd stride or sel).

// One output channel: seed load or modular accumulate.
module hos_lane #(
  parameter int WIDTH     = 32,
  parameter int IDX       = 0,
  parameter int INIT_BASE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             upd,
  input  logic             use_sel,
  input  logic [WIDTH-1:0] sel_q,
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT_BASE * (IDX + 1));
  localparam logic [WIDTH-1:0] STRIDE   = WIDTH'(2 * IDX + 1);

  // Channel register; additions wrap silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= '0;
    else if (load) q <= INIT_VAL;
    else if (upd)  q <= q + (use_sel ? sel_q : STRIDE);
  end
endmodule

module hard_out_sequencer #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 3,
  parameter int STEPS     = 4,
  parameter int INIT_BASE = 10
) (
  input  logic             clk,
  input  logic             reset,
  hard_out_sequencer_if.slave bus
);
  localparam int STEP_W = $clog2(STEPS + 1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

  typedef enum logic [7:0] {
    INIT = 8'd0,
    IDLE = 8'd1,
    RUN  = 8'd2,
    DONE = 8'd3
  } state_t;

  state_t                        state, state_nxt;
  logic [WIDTH-1:0]              sel_q;
  logic [STEP_W-1:0]             step_q;
  logic [CHANNELS-1:0][WIDTH-1:0] chan;
  logic                          load_init, accept, upd, sel_nz;

  // State register; reset lands in INIT so the seeds load on the first edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_nxt;
  end

  // Next state; reload beats start in IDLE, stray encodings recover via INIT.
  always_comb begin
    state_nxt = INIT;
    case (state)
      INIT: state_nxt = IDLE;
      IDLE: state_nxt = bus.reload ? INIT : (bus.start ? RUN : IDLE);
      RUN:  state_nxt = (!bus.hold && step_q == LAST) ? DONE : RUN;
      DONE: state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Decoded strobes and status, all derived from the state register.
  always_comb begin
    load_init = (state == INIT);
    accept    = (state == IDLE) && !bus.reload && bus.start;
    upd       = (state == RUN) && !bus.hold;
    bus.busy  = (state == RUN);
    bus.done  = (state == DONE);
  end

  // Step counter and selector capture; sel_q stays frozen for the whole run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
      sel_q  <= '0;
    end else if (load_init) begin
      step_q <= '0;
    end else if (accept) begin
      step_q <= '0;
      sel_q  <= bus.sel;
    end else if (upd) begin
      step_q <= step_q + STEP_W'(1);
    end
  end

  assign sel_nz = (sel_q != '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    hos_lane #(.WIDTH(WIDTH), .IDX(i), .INIT_BASE(INIT_BASE)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (load_init),
      .upd     (upd),
      .use_sel (sel_nz),
      .sel_q   (sel_q),
      .q       (chan[i])
    );
  end

  assign bus.out_bus = chan;
  assign bus.step    = step_q;
endmodule

// File: tb/tb_hard_out_sequencer.sv
// Randomised bench for hard_out_sequencer against a closed-form channel model.
module tb_hard_out_sequencer;
  localparam int W  = 32;
  localparam int C  = 3;
  localparam int S  = 4;
  localparam int SW = $clog2(S + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hard_out_sequencer_if #(.WIDTH(W), .CHANNELS(C), .STEPS(S)) bus();

  hard_out_sequencer #(.WIDTH(W), .CHANNELS(C), .STEPS(S), .INIT_BASE(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] m [C];

  function automatic logic [C*W-1:0] exp_bus();
    logic [C*W-1:0] r;
    for (int i = 0; i < C; i++) r[i*W +: W] = m[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < C; i++) m[i] = W'(10 * (i + 1));
  endtask

  task automatic test_reset();
    bus.start = 0; bus.reload = 0; bus.hold = 0; bus.sel = '0;
    #2;
    checks++;
    if (bus.out_bus !== '0) begin failures++; $display("FAIL reset_bus got=%h exp=0", bus.out_bus); end
    checks++;
    if ({bus.busy, bus.done, bus.step} !== {1'b0, 1'b0, SW'(0)}) begin
      failures++; $display("FAIL reset_status got=%b exp=0", {bus.busy, bus.done, bus.step});
    end
    tick(); tick();
    reset = 1'b1;
    checks++;
    if (bus.out_bus !== '0) begin failures++; $display("FAIL pre_init_bus got=%h exp=0", bus.out_bus); end
    tick(); tick();
    model_init();
    checks++;
    if (bus.out_bus !== exp_bus()) begin failures++; $display("FAIL init_bus got=%h exp=%h", bus.out_bus, exp_bus()); end
    checks++;
    if ({bus.busy, bus.done, bus.step} !== {1'b0, 1'b0, SW'(0)}) begin
      failures++; $display("FAIL init_status got=%b exp=0", {bus.busy, bus.done, bus.step});
    end
  endtask

  // One complete run from IDLE; hold_at/hold_len force a stall after a given update count.
  task automatic do_run(input string name, input logic [W-1:0] s, input int hold_at,
                        input int hold_len, input bit rand_hold, input bit keep_start);
    logic [W-1:0] start_v [C];
    logic [W-1:0] inc [C];
    int k;
    int holds;
    for (int i = 0; i < C; i++) begin
      start_v[i] = m[i];
      inc[i] = (s == '0) ? W'(2 * i + 1) : s;
    end
    bus.start = 1; bus.sel = s; bus.reload = 0; bus.hold = 0;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.step} !== {1'b1, 1'b0, SW'(0)} || bus.out_bus !== exp_bus()) begin
      failures++;
      $display("FAIL %s_accept status=%b bus=%h exp status=10%0d bus=%h", name,
               {bus.busy, bus.done, bus.step}, bus.out_bus, 0, exp_bus());
    end
    bus.start = keep_start;
    k = 0; holds = 0;
    for (int c = 0; c < 64 && k < S; c++) begin
      bit h;
      h = 0;
      if (k == hold_at && holds < hold_len) h = 1;
      else if (rand_hold && holds < 6 && $urandom_range(0, 3) == 0) h = 1;
      if (h) holds++;
      bus.hold = h; bus.sel = $urandom; bus.reload = 1'($urandom_range(0, 1));
      tick();
      if (!h) begin
        k++;
        for (int i = 0; i < C; i++) m[i] = m[i] + inc[i];
      end
      checks++;
      if (bus.out_bus !== exp_bus()) begin
        failures++; $display("FAIL %s_bus k=%0d got=%h exp=%h", name, k, bus.out_bus, exp_bus());
      end
      checks++;
      if ({bus.busy, bus.done, bus.step} !== {(k < S), (k >= S), SW'(k)}) begin
        failures++;
        $display("FAIL %s_status k=%0d got busy=%b done=%b step=%0d", name, k, bus.busy, bus.done, bus.step);
      end
    end
    if (k < S) begin
      checks++; failures++;
      $display("FAIL %s_timeout updates=%0d exp=%0d", name, k, S);
    end
    for (int i = 0; i < C; i++) begin
      checks++;
      if (bus.out_bus[i*W +: W] !== start_v[i] + W'(S) * inc[i]) begin
        failures++;
        $display("FAIL %s_final ch%0d got=%h exp=%h", name, i, bus.out_bus[i*W +: W], start_v[i] + W'(S) * inc[i]);
      end
    end
    bus.hold = 1'($urandom_range(0, 1)); bus.reload = 1'($urandom_range(0, 1)); bus.sel = $urandom;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.step} !== {1'b0, 1'b0, SW'(S)} || bus.out_bus !== exp_bus()) begin
      failures++;
      $display("FAIL %s_idle got busy=%b done=%b step=%0d bus=%h exp bus=%h", name,
               bus.busy, bus.done, bus.step, bus.out_bus, exp_bus());
    end
    bus.reload = 0; bus.hold = 0; bus.start = keep_start;
  endtask

  task automatic test_reload();
    bus.reload = 1;
    tick();
    bus.reload = 0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reload_busy got=%b exp=0", bus.busy); end
    tick();
    model_init();
    checks++;
    if (bus.out_bus !== exp_bus() || bus.step !== SW'(0)) begin
      failures++; $display("FAIL reload_vals got=%h step=%0d exp=%h step=0", bus.out_bus, bus.step, exp_bus());
    end
  endtask

  task automatic test_priority();
    bus.start = 1; bus.reload = 1; bus.sel = 32'd7;
    tick();
    bus.start = 0; bus.reload = 0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL prio_busy got=%b exp=0", bus.busy); end
    tick();
    model_init();
    checks++;
    if (bus.out_bus !== exp_bus() || {bus.busy, bus.done, bus.step} !== {1'b0, 1'b0, SW'(0)}) begin
      failures++; $display("FAIL prio_vals got=%h busy=%b exp=%h busy=0", bus.out_bus, bus.busy, exp_bus());
    end
  endtask

  task automatic test_reset_midrun();
    int dn;
    bus.start = 1; bus.sel = '0;
    tick();
    bus.start = 0;
    tick(); tick();
    for (int i = 0; i < C; i++) m[i] = m[i] + W'(2 * (2 * i + 1));
    checks++;
    if (bus.out_bus !== exp_bus()) begin failures++; $display("FAIL midrun_bus got=%h exp=%h", bus.out_bus, exp_bus()); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.out_bus !== '0 || {bus.busy, bus.done, bus.step} !== {1'b0, 1'b0, SW'(0)}) begin
      failures++; $display("FAIL midrun_reset got=%h status=%b exp=0", bus.out_bus, {bus.busy, bus.done, bus.step});
    end
    tick();
    reset = 1'b1;
    tick();
    model_init();
    checks++;
    if (bus.out_bus !== exp_bus()) begin failures++; $display("FAIL midrun_reinit got=%h exp=%h", bus.out_bus, exp_bus()); end
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.done || bus.busy) dn++;
    end
    checks++;
    if (dn != 0) begin failures++; $display("FAIL midrun_no_done got=%0d cycles active exp=0", dn); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      logic [W-1:0] s;
      if ($urandom_range(0, 2) == 0) test_reload();
      s = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom);
      do_run("rand", s, -1, 0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    do_run("sel0", '0, -1, 0, 1'b0, 1'b0);
    test_reload();
    do_run("sel5", 32'd5, -1, 0, 1'b0, 1'b0);
    do_run("wrap", 32'hFFFF_FFFF, -1, 0, 1'b0, 1'b0);
    test_reload();
    do_run("hold", '0, 2, 3, 1'b0, 1'b0);
    test_reset_midrun();
    test_priority();
    do_run("held1", W'($urandom), -1, 0, 1'b0, 1'b1);
    do_run("held2", '0, -1, 0, 1'b0, 1'b0);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
